// File: rtl/uart_ahb_debug_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_ahb_debug_bridge_if
// Purpose  : UART byte handshake, core reset and AHB-Lite master signal bundle.
// Revision : 1.0
// ============================================================================
interface uart_ahb_debug_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_byte;
  logic              received;
  logic              sent;
  logic [7:0]        tx_byte;
  logic              transmit;
  logic              M0_RST;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HWDATA;

  modport master (
    input  rx_byte, received, sent, HREADY, HRDATA,
    output tx_byte, transmit, M0_RST, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
  );

  modport slave (
    output rx_byte, received, sent, HREADY, HRDATA,
    input  tx_byte, transmit, M0_RST, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
  );
endinterface
`default_nettype wire

// File: rtl/uart_ahb_debug_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_ahb_debug_bridge
// Purpose  : UART byte-command parser driving single AHB-Lite transfers and the core reset line.
// Revision : 1.0
// ============================================================================
module uart_ahb_debug_bridge #(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 4,
  parameter int RX_TIMEOUT  = 50000,
  parameter int BUS_TIMEOUT = 1024,
  parameter bit RST_INIT    = 1'b1
) (
  input wire clk,
  input wire rst_n,
  uart_ahb_debug_bridge_if.master bus
);

  localparam int ADDR_W    = 8 * ADDR_BYTES;
  localparam int DATA_W    = 8 * DATA_BYTES;
  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
  localparam int RXT_W     = $clog2(RX_TIMEOUT + 1);
  localparam int BUST_W    = $clog2(BUS_TIMEOUT + 1);
  localparam int HSIZE_VAL = $clog2(DATA_BYTES);

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_RST_SET = 8'h03;
  localparam logic [7:0] OP_RST_CLR = 8'h04;
  localparam logic [7:0] RSP_ACK    = 8'hA5;
  localparam logic [7:0] RSP_ERR    = 8'hEE;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_ADDR  = 3'd1,
    S_GET_LEN   = 3'd2,
    S_GET_WDATA = 3'd3,
    S_BUS_ADDR  = 3'd4,
    S_BUS_DATA  = 3'd5,
    S_TX_BYTE   = 3'd6,
    S_TX_WAIT   = 3'd7
  } state_t;

  state_t              state_q,   state_d;
  logic                write_q,   write_d;
  logic                rd_q,      rd_d;
  logic                m0_q,      m0_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic [7:0]          words_q,   words_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [7:0]          tx_q,      tx_d;
  logic [RXT_W-1:0]    rx_tmr_q,  rx_tmr_d;
  logic [BUST_W-1:0]   bus_tmr_q, bus_tmr_d;

  logic                w_in_get;
  logic [DATA_W-1:0]   w_data_shl;
  logic [ADDR_W-1:0]   w_addr_next;

  assign w_in_get    = (state_q == S_GET_ADDR) || (state_q == S_GET_LEN) ||
                       (state_q == S_GET_WDATA);
  assign w_data_shl  = data_q << 8;
  assign w_addr_next = addr_q + ADDR_W'(DATA_BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      rd_q      <= 1'b0;
      m0_q      <= RST_INIT;
      addr_q    <= '0;
      data_q    <= '0;
      words_q   <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_tmr_q  <= '0;
      bus_tmr_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      rd_q      <= rd_d;
      m0_q      <= m0_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      words_q   <= words_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_tmr_q  <= rx_tmr_d;
      bus_tmr_q <= bus_tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    rd_d      = rd_q;
    m0_d      = m0_q;
    addr_d    = addr_q;
    data_d    = data_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_tmr_d  = '0;
    bus_tmr_d = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.received) begin
          cnt_d = '0;
          rd_d  = 1'b0;
          case (bus.rx_byte)
            OP_READ: begin
              write_d = 1'b0;
              state_d = S_GET_ADDR;
            end
            OP_WRITE: begin
              write_d = 1'b1;
              state_d = S_GET_ADDR;
            end
            OP_RST_SET: begin
              m0_d    = 1'b1;
              tx_d    = RSP_ACK;
              state_d = S_TX_BYTE;
            end
            OP_RST_CLR: begin
              m0_d    = 1'b0;
              tx_d    = RSP_ACK;
              state_d = S_TX_BYTE;
            end
            default: begin
              tx_d    = RSP_ERR;
              state_d = S_TX_BYTE;
            end
          endcase
        end
      end

      S_GET_ADDR: begin
        if (bus.received) begin
          addr_d = (addr_q << 8) | ADDR_W'(bus.rx_byte);
          if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_GET_LEN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_GET_LEN: begin
        if (bus.received) begin
          words_d = bus.rx_byte;
          cnt_d   = '0;
          state_d = write_q ? S_GET_WDATA : S_BUS_ADDR;
        end
      end

      S_GET_WDATA: begin
        if (bus.received) begin
          data_d = (data_q << 8) | DATA_W'(bus.rx_byte);
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_BUS_ADDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_BUS_ADDR: state_d = S_BUS_DATA;

      S_BUS_DATA: begin
        if (bus.HREADY) begin
          if (write_q) begin
            if (words_q == 8'd0) begin
              tx_d    = RSP_ACK;
              state_d = S_TX_BYTE;
            end else begin
              words_d = words_q - 1'b1;
              addr_d  = w_addr_next;
              cnt_d   = '0;
              state_d = S_GET_WDATA;
            end
          end else begin
            data_d  = bus.HRDATA;
            tx_d    = bus.HRDATA[DATA_W-1 -: 8];
            cnt_d   = '0;
            rd_d    = 1'b1;
            state_d = S_TX_BYTE;
          end
        end else if (bus_tmr_q == BUST_W'(BUS_TIMEOUT - 1)) begin
          // Stalled slave: report error and abandon the remaining words.
          tx_d    = RSP_ERR;
          rd_d    = 1'b0;
          state_d = S_TX_BYTE;
        end else begin
          bus_tmr_d = bus_tmr_q + 1'b1;
        end
      end

      S_TX_BYTE: state_d = S_TX_WAIT;

      S_TX_WAIT: begin
        if (bus.sent) begin
          if (!rd_q) begin
            state_d = S_IDLE;
          end else if (cnt_q != CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = cnt_q + 1'b1;
            data_d  = w_data_shl;
            tx_d    = w_data_shl[DATA_W-1 -: 8];
            state_d = S_TX_BYTE;
          end else if (words_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            words_d = words_q - 1'b1;
            addr_d  = w_addr_next;
            state_d = S_BUS_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Host went quiet mid-frame: drop the frame without answering.
    if (w_in_get && !bus.received) begin
      if (rx_tmr_q == RXT_W'(RX_TIMEOUT - 1)) begin
        state_d = S_IDLE;
      end else begin
        rx_tmr_d = rx_tmr_q + 1'b1;
      end
    end
  end

  assign bus.tx_byte  = tx_q;
  assign bus.transmit = (state_q == S_TX_BYTE);
  assign bus.M0_RST   = m0_q;
  assign bus.HADDR    = addr_q;
  assign bus.HWRITE   = write_q;
  assign bus.HSIZE    = 3'(HSIZE_VAL);
  assign bus.HBURST   = 3'b000;
  assign bus.HTRANS   = (state_q == S_BUS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HWDATA   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ahb_debug_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_ahb_debug_bridge
// Purpose  : Randomised self-checking bench with a scoreboard model of the bridge protocol.
// Revision : 1.0
// ============================================================================
module tb_uart_ahb_debug_bridge;
  localparam int AB  = 4;
  localparam int DB  = 4;
  localparam int RXT = 64;
  localparam int BT  = 1024;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } bus_op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_ahb_debug_bridge_if #(.ADDR_W(8*AB), .DATA_W(8*DB)) bus ();

  uart_ahb_debug_bridge #(
    .ADDR_BYTES (AB),
    .DATA_BYTES (DB),
    .RX_TIMEOUT (RXT),
    .BUS_TIMEOUT(BT),
    .RST_INIT   (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bus_op_t     exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_tx[$];
  logic [31:0] obs_wdata;
  logic [31:0] wbuf[256];
  logic [31:0] rbuf[256];
  int          addr_cyc, tx_cyc;
  int          done_cnt = 0;
  int          abort_gen = 0;
  int          abort_seen = 0;
  bit          m0_exp = 1'b1;
  bit          chk_en = 1'b0;
  bit          stall = 1'b0;
  bit          pend = 1'b0;
  bus_op_t     cur;
  int          wcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave responder plus per-cycle comparison against the scoreboard.
  always @(negedge clk) begin
    if (abort_gen != abort_seen) begin
      pend       = 1'b0;
      abort_seen = abort_gen;
    end
    if (chk_en) begin
      chk("m0_rst", bus.M0_RST, m0_exp);
      chk("htrans_legal", (bus.HTRANS == 2'b00) || (bus.HTRANS == 2'b10), 1'b1);
      chk("hsize", bus.HSIZE, 3'd2);
      chk("hburst", bus.HBURST, 3'd0);
    end
    if (chk_en && bus.HTRANS == 2'b10) begin
      if (exp_bus.size() == 0) begin
        chk("unexpected_nonseq", bus.HADDR, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        cur = exp_bus.pop_front();
        chk("haddr", bus.HADDR, cur.addr);
        chk("hwrite", bus.HWRITE, cur.wr);
        obs_addr.push_back(bus.HADDR);
        addr_cyc = cyc;
        pend     = 1'b1;
        wcnt     = cur.waits;
      end
      bus.HREADY = 1'b0;
    end else if (pend) begin
      if (wcnt == 0 && !stall) begin
        bus.HREADY = 1'b1;
        bus.HRDATA = cur.rdata;
        if (cur.wr) chk("hwdata", bus.HWDATA, cur.wdata);
        obs_wdata = bus.HWDATA;
        pend      = 1'b0;
        done_cnt++;
      end else begin
        bus.HREADY = 1'b0;
        bus.HRDATA = $urandom;
        wcnt--;
      end
    end else begin
      bus.HREADY = 1'($urandom_range(0, 1));
      bus.HRDATA = $urandom;
    end
    if (chk_en && bus.transmit) begin
      tx_cyc = cyc;
      obs_tx.push_back(bus.tx_byte);
      if (exp_tx.size() == 0) chk("unexpected_tx", bus.tx_byte, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("tx_byte", bus.tx_byte, exp_tx.pop_front());
    end
  end

  // UART transmitter: acknowledge each byte after a short random delay.
  initial begin
    bus.sent = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.transmit) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bus.sent = 1'b1;
        @(posedge clk);
        #1 bus.sent = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rgap();
    return $urandom_range(0, 3);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_byte  = b;
    bus.received = 1'b1;
    tick();
    bus.received = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    chk({nm, "_complete"}, exp_tx.size() + exp_bus.size(), 0);
    repeat (8) tick();
  endtask

  task automatic wait_bus(input int target);
    int n = 0;
    while (done_cnt < target && n < 4000) begin
      tick();
      n++;
    end
    chk("bus_word_done", done_cnt >= target, 1'b1);
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input bit directed);
    bus_op_t op;
    int base;
    for (int i = 0; i <= len; i++) begin
      if (!directed) wbuf[i] = $urandom;
      op.addr  = addr + 32'(i * DB);
      op.wr    = 1'b1;
      op.wdata = wbuf[i];
      op.rdata = $urandom;
      op.waits = $urandom_range(0, 3);
      exp_bus.push_back(op);
    end
    exp_tx.push_back(8'hA5);
    base = done_cnt;
    send_byte(8'h02, rgap());
    for (int b = AB - 1; b >= 0; b--) send_byte(addr[8*b +: 8], rgap());
    send_byte(8'(len), rgap());
    for (int i = 0; i <= len; i++) begin
      for (int b = DB - 1; b >= 0; b--) send_byte(wbuf[i][8*b +: 8], (b == 0) ? 0 : rgap());
      wait_bus(base + i + 1);
    end
    wait_done("write");
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit directed,
                         input int waits, input int opgap);
    bus_op_t op;
    for (int i = 0; i <= len; i++) begin
      op.addr  = addr + 32'(i * DB);
      op.wr    = 1'b0;
      op.wdata = '0;
      op.rdata = directed ? rbuf[i] : $urandom;
      op.waits = (waits < 0) ? $urandom_range(0, 3) : waits;
      exp_bus.push_back(op);
      for (int b = DB - 1; b >= 0; b--) exp_tx.push_back(op.rdata[8*b +: 8]);
    end
    send_byte(8'h01, (opgap < 0) ? rgap() : opgap);
    for (int b = AB - 1; b >= 0; b--) send_byte(addr[8*b +: 8], rgap());
    send_byte(8'(len), 0);
    wait_done("read");
  endtask

  task automatic do_simple(input logic [7:0] op);
    exp_tx.push_back((op == 8'h03 || op == 8'h04) ? 8'hA5 : 8'hEE);
    bus.rx_byte  = op;
    bus.received = 1'b1;
    tick();
    bus.received = 1'b0;
    if (op == 8'h03) m0_exp = 1'b1;
    else if (op == 8'h04) m0_exp = 1'b0;
    wait_done("simple");
  endtask

  initial begin
    int s, a;
    int sel, len;
    logic [7:0] uop;
    logic [31:0] ra;
    bus.rx_byte  = '0;
    bus.received = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_htrans", bus.HTRANS, 2'b00);
    chk("reset_transmit", bus.transmit, 1'b0);
    chk("reset_m0", bus.M0_RST, 1'b1);
    chk("reset_haddr", bus.HADDR, 32'h0);
    chk("reset_hwrite", bus.HWRITE, 1'b0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    tick();

    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h0000_1000, 0, 1'b1);
    chk("wr_haddr_lit", obs_addr[obs_addr.size()-1], 32'h0000_1000);
    chk("wr_hwdata_lit", obs_wdata, 32'hDEADBEEF);
    chk("wr_ack_lit", obs_tx[obs_tx.size()-1], 8'hA5);

    rbuf[0] = 32'h11; rbuf[1] = 32'h22; rbuf[2] = 32'h33;
    s = obs_tx.size();
    a = obs_addr.size();
    do_read(32'h0000_1000, 2, 1'b1, 3, -1);
    chk("rd_tx_count", obs_tx.size() - s, 12);
    chk("rd_byte0_lit", obs_tx[s], 8'h00);
    chk("rd_byte3_lit", obs_tx[s+3], 8'h11);
    chk("rd_byte7_lit", obs_tx[s+7], 8'h22);
    chk("rd_byte11_lit", obs_tx[s+11], 8'h33);
    chk("rd_addr1_lit", obs_addr[a+1], 32'h0000_1004);
    chk("rd_addr2_lit", obs_addr[a+2], 32'h0000_1008);

    wbuf[0] = 32'h0123_4567; wbuf[1] = 32'h89AB_CDEF;
    a = obs_addr.size();
    do_write(32'hFFFF_FFFC, 1, 1'b1);
    chk("wrap_addr0_lit", obs_addr[a], 32'hFFFF_FFFC);
    chk("wrap_addr1_lit", obs_addr[a+1], 32'h0000_0000);

    do_simple(8'h7F);
    chk("badop_lit", obs_tx[obs_tx.size()-1], 8'hEE);
    do_simple(8'h04);
    chk("m0_clear_lit", bus.M0_RST, 1'b0);
    do_simple(8'h03);
    chk("m0_set_lit", bus.M0_RST, 1'b1);

    // Longest tolerated silence between command bytes.
    do_read(32'h0000_4000, 0, 1'b0, -1, RXT - 1);

    s = obs_tx.size();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (RXT + 10) tick();
    chk("partial_no_tx", obs_tx.size() - s, 0);
    do_simple(8'h04);

    stall = 1'b1;
    begin
      bus_op_t op;
      op.addr = 32'h0000_3000; op.wr = 1'b0; op.wdata = '0; op.rdata = 32'h5A5A_5A5A; op.waits = 0;
      exp_bus.push_back(op);
    end
    exp_tx.push_back(8'hEE);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    wait_done("bus_timeout");
    chk("bus_to_cycles", tx_cyc - addr_cyc, BT + 1);
    chk("bus_to_err_lit", obs_tx[obs_tx.size()-1], 8'hEE);
    stall = 1'b0;
    abort_gen++;
    tick();

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(0, 3);
      ra  = $urandom;
      if (sel < 4) begin
        do_write(ra, len, 1'b0);
      end else if (sel < 8) begin
        do_read(ra, len, 1'b0, -1, -1);
      end else if (sel == 8) begin
        do_simple(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h04);
      end else begin
        uop = 8'($urandom_range(0, 255));
        while (uop >= 8'h01 && uop <= 8'h04) uop = 8'($urandom_range(0, 255));
        do_simple(uop);
      end
    end

    // Reset asserted during a read address phase.
    begin
      bus_op_t op;
      op.addr = 32'h0000_2000; op.wr = 1'b0; op.wdata = '0; op.rdata = 32'hCAFE_F00D; op.waits = 50;
      exp_bus.push_back(op);
      for (int b = DB - 1; b >= 0; b--) exp_tx.push_back(op.rdata[8*b +: 8]);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("rst_mid_nonseq", bus.HTRANS, 2'b10);
    rst_n = 1'b0;
    tick();
    m0_exp = 1'b1;
    exp_tx.delete();
    exp_bus.delete();
    abort_gen++;
    chk("rst_mid_htrans", bus.HTRANS, 2'b00);
    chk("rst_mid_haddr", bus.HADDR, 32'h0);
    chk("rst_mid_m0", bus.M0_RST, 1'b1);
    rst_n = 1'b1;
    repeat (60) tick();
    do_simple(8'h04);
    do_read(32'h0000_5000, 1, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
